matrix_loader: RTL

Upstream feeder for the 3x3 matrix multiplier (Calculator).
- Accepts a serial stream of 8-bit matrix elements over a valid/ready byte interface.
- Assembles operand buses A and B, then issues a single-cycle enable_multiplication pulse.
- Holds operands stable until the multiplier reports mult_done, or until a watchdog expires, then re-arms for the next frame.

---
 rtl/matmul_pkg.sv | 21 ++
 rtl/matrix_loader_if.sv | 44 ++++
 rtl/mult_done_watchdog.sv | 53 +++++
 rtl/matrix_loader.sv | 113 +++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared constants and types for the 3x3 matrix multiplier feeder.
// Element width, matrix size, bus width and loader state encoding.
package matmul_pkg;

  localparam int ELEM_W      = 8;
  localparam int N           = 3;
  localparam int ELEMS       = N * N;
  localparam int MAT_W       = ELEMS * ELEM_W;
  localparam int FRAME_BYTES = 2 * ELEMS;
  localparam int IDX_W       = $clog2(FRAME_BYTES);

  typedef logic [ELEM_W-1:0] elem_t;
  typedef logic [MAT_W-1:0]  mat_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } ld_state_e;

endpackage

// File: rtl/matrix_loader_if.sv
// Byte stream in, operand buses and multiplier handshake out.
// master drives bytes and mult_done; slave is the loader.
interface matrix_loader_if
  import matmul_pkg::*;
();

  elem_t in_data;
  logic  in_valid;
  logic  in_ready;
  mat_t  A;
  mat_t  B;
  logic  enable_multiplication;
  logic  mult_done;
  logic  busy;
  logic  frame_done;
  logic  timeout;

  modport master (
    output in_data,
    output in_valid,
    output mult_done,
    input  in_ready,
    input  A,
    input  B,
    input  enable_multiplication,
    input  busy,
    input  frame_done,
    input  timeout
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mult_done,
    output in_ready,
    output A,
    output B,
    output enable_multiplication,
    output busy,
    output frame_done,
    output timeout
  );

endinterface

// File: rtl/mult_done_watchdog.sv
// Rising-edge detector on mult_done plus the WAIT-state watchdog.
// expired is high on the WAIT cycle where the count hits the limit.
module mult_done_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic mult_done,
  output logic done_edge,
  output logic expired
);

  localparam int CNT_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= mult_done;
    end
  end

  assign done_edge = mult_done & ~prev_q;

  generate
    if (TIMEOUT_CYCLES > 0) begin : g_wd
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q <= '0;
        end else if (clear) begin
          cnt_q <= '0;
        end else if (run) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign expired =
        run && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_wd
      logic unused_ctl;
      assign unused_ctl = clear ^ run;
      assign expired    = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/matrix_loader.sv
// Serial byte loader: assembles A/B, fires the multiplier once,
// then waits for mult_done (or the watchdog) before re-arming.
module matrix_loader
  import matmul_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic            clk,
  input logic            rst,
  matrix_loader_if.slave bus
);

  ld_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  mat_t             a_q, b_q;
  logic             in_ready_q;
  logic             enable_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             timeout_q;
  logic             accept, last;
  logic             wd_clear, wd_run;
  logic             done_edge, expired;

  assign accept = bus.in_valid & in_ready_q;
  assign last   = idx_q == IDX_W'(FRAME_BYTES - 1);

  mult_done_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk       (clk),
    .rst       (rst),
    .clear     (wd_clear),
    .run       (wd_run),
    .mult_done (bus.mult_done),
    .done_edge (done_edge),
    .expired   (expired)
  );

  always_comb begin
    state_d  = state_q;
    wd_clear = 1'b0;
    wd_run   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (accept && last) state_d = FIRE;
      end
      FIRE: begin
        wd_clear = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        wd_run = 1'b1;
        if (done_edge || expired) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Status flags are registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      in_ready_q   <= 1'b1;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= state_d == LOAD;
      enable_q     <= state_d == FIRE;
      busy_q       <= state_d != LOAD;
      frame_done_q <= wd_run & done_edge;
      timeout_q    <= wd_run & expired & ~done_edge;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (accept) begin
      idx_q <= last ? '0 : idx_q + 1'b1;
    end else if (state_q != LOAD) begin
      idx_q <= '0;
    end
  end

  // Element k lives at the MSB end shifted down by k bytes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      for (int k = 0; k < ELEMS; k++) begin
        if (idx_q == IDX_W'(k))
          a_q[MAT_W-1-ELEM_W*k -: ELEM_W] <= bus.in_data;
        if (idx_q == IDX_W'(k + ELEMS))
          b_q[MAT_W-1-ELEM_W*k -: ELEM_W] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready              = in_ready_q;
  assign bus.A                     = a_q;
  assign bus.B                     = b_q;
  assign bus.enable_multiplication = enable_q;
  assign bus.busy                  = busy_q;
  assign bus.frame_done            = frame_done_q;
  assign bus.timeout               = timeout_q;

endmodule
